// File: rtl/memarb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package memarb_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;
   localparam int unsigned DEFAULT_MEM_DEPTH = 1048576;

   typedef enum logic {IDLE, RMW_WR} state_t;
   typedef enum logic {FETCH, DATA} req_id_t;

endpackage

// File: rtl/mem_port_arbiter_lane.sv
// mem_lane_unit: combinational store-lane merge and load-lane extract/extend.
module mem_lane_unit
   import memarb_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] st_data,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        zero_ext,
   output logic [31:0] merged_word,
   output logic [31:0] load_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Load path: pick the addressed lane, then sign- or zero-extend.
   always_comb begin
      ld_byte = rd_word[7:0];
      case (offset)
         2'd0: ld_byte = rd_word[7:0];
         2'd1: ld_byte = rd_word[15:8];
         2'd2: ld_byte = rd_word[23:16];
         2'd3: ld_byte = rd_word[31:24];
      endcase
      ld_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
      load_data = rd_word;
      case (size)
         SIZE_BYTE:            load_data = {{24{~zero_ext & ld_byte[7]}}, ld_byte};
         SIZE_HALF:            load_data = {{16{~zero_ext & ld_half[15]}}, ld_half};
         SIZE_WORD, SIZE_RSVD: load_data = rd_word;
      endcase
   end

   // Store path: new right-aligned lanes replace the old ones in the read word.
   always_comb begin
      merged_word = rd_word;
      case (size)
         SIZE_BYTE: begin
            case (offset)
               2'd0: merged_word[7:0]   = st_data[7:0];
               2'd1: merged_word[15:8]  = st_data[7:0];
               2'd2: merged_word[23:16] = st_data[7:0];
               2'd3: merged_word[31:24] = st_data[7:0];
            endcase
         end
         SIZE_HALF: begin
            if (offset[1]) merged_word[31:16] = st_data[15:0];
            else           merged_word[15:0]  = st_data[15:0];
         end
         SIZE_WORD, SIZE_RSVD: merged_word = st_data;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for the single unified memory port, with sub-word RMW stores.
// Optional address/alignment checking is enabled by defining MEMARB_CHECK_EN.
module mem_port_arbiter
   import memarb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_gnt,
   output logic        f_rsp_valid,
   output logic        f_rsp_err,
   output logic [31:0] f_rsp_data,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_unsigned,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rsp_valid,
   output logic        d_rsp_err,
   output logic [31:0] d_rsp_data,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_read_write,
   input  logic [31:0] mem_data_out
);

   state_t      state_q;
   req_id_t     last_gnt_q;
   logic [31:0] merge_q;
   logic [31:0] rmw_addr_q;

   logic        f_fault;
   logic        d_fault;
   logic        d_sub_store;
   logic [31:0] merged_word;
   logic [31:0] load_data;

`ifdef MEMARB_CHECK_EN
   function automatic logic in_window(input logic [31:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_DEPTH);
   endfunction

   assign f_fault = !in_window(f_addr) || (f_addr[1:0] != 2'b00);
   assign d_fault = !in_window(d_addr)
                 || ((d_size == SIZE_HALF) && d_addr[0])
                 || ((d_size == SIZE_WORD) && (d_addr[1:0] != 2'b00))
                 || (d_size == SIZE_RSVD);
`else
   assign f_fault = 1'b0;
   assign d_fault = 1'b0;
`endif

   assign d_sub_store = d_we && ((d_size == SIZE_BYTE) || (d_size == SIZE_HALF));

   // Merge is done in the grant cycle so merge_q already holds the word to write.
   mem_lane_unit u_lane (
      .rd_word     (mem_data_out),
      .st_data     (d_wdata),
      .offset      (d_addr[1:0]),
      .size        (d_size),
      .zero_ext    (d_unsigned),
      .merged_word (merged_word),
      .load_data   (load_data)
   );

   // Arbitration: alternate under contention, nothing granted while an RMW write is pending.
   always_comb begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset && (state_q == IDLE)) begin
         if (f_req && d_req) begin
            d_gnt = (last_gnt_q == FETCH);
            f_gnt = (last_gnt_q == DATA);
         end else begin
            f_gnt = f_req;
            d_gnt = d_req;
         end
      end
   end

   // Memory port drive; reset forces the idle values and suppresses any write.
   always_comb begin
      mem_address    = BASE_ADDR;
      mem_data_in    = '0;
      mem_read_write = 1'b0;
      if (!reset) begin
         if (state_q == RMW_WR) begin
            mem_address    = rmw_addr_q;
            mem_data_in    = merge_q;
            mem_read_write = 1'b1;
         end else if (f_gnt && !f_fault) begin
            mem_address = f_addr & ~32'd3;
         end else if (d_gnt && !d_fault) begin
            mem_address = d_addr & ~32'd3;
            if (d_we && !d_sub_store) begin
               mem_data_in    = d_wdata;
               mem_read_write = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         last_gnt_q  <= FETCH;
         merge_q     <= '0;
         rmw_addr_q  <= BASE_ADDR;
         f_rsp_valid <= 1'b0;
         f_rsp_err   <= 1'b0;
         f_rsp_data  <= '0;
         d_rsp_valid <= 1'b0;
         d_rsp_err   <= 1'b0;
         d_rsp_data  <= '0;
      end else begin
         f_rsp_valid <= f_gnt;
         f_rsp_err   <= f_gnt && f_fault;
         f_rsp_data  <= (f_gnt && !f_fault) ? mem_data_out : '0;
         d_rsp_valid <= 1'b0;
         d_rsp_err   <= 1'b0;
         d_rsp_data  <= '0;

         if (f_gnt)      last_gnt_q <= FETCH;
         else if (d_gnt) last_gnt_q <= DATA;

         case (state_q)
            IDLE: begin
               if (d_gnt) begin
                  if (d_fault) begin
                     d_rsp_valid <= 1'b1;
                     d_rsp_err   <= 1'b1;
                  end else if (d_sub_store) begin
                     merge_q    <= merged_word;
                     rmw_addr_q <= d_addr & ~32'd3;
                     state_q    <= RMW_WR;
                  end else begin
                     d_rsp_valid <= 1'b1;
                     d_rsp_data  <= d_we ? 32'd0 : load_data;
                  end
               end
            end
            RMW_WR: begin
               d_rsp_valid <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

   localparam logic [31:0] BASE   = 32'h0100_0000;
   localparam int unsigned DEPTH  = 1048576;
   localparam int unsigned NWORDS = 256;
`ifdef MEMARB_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        f_req, d_req, d_we, d_unsigned;
   logic [31:0] f_addr, d_addr, d_wdata;
   logic [1:0]  d_size;
   logic        f_gnt, f_rsp_valid, f_rsp_err;
   logic        d_gnt, d_rsp_valid, d_rsp_err;
   logic [31:0] f_rsp_data, d_rsp_data;
   logic [31:0] mem_address, mem_data_in, mem_data_out;
   logic        mem_read_write;

   logic [31:0] phys    [NWORDS];
   logic [31:0] ref_mem [NWORDS];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit          last_was_data;
   bit          rmw_pend;
   logic [31:0] rmw_a, rmw_w;
   bit          obs_fg, obs_dg, obs_we;

   always #5 clock = ~clock;

   mem_port_arbiter dut (
      .clock          (clock),
      .reset          (reset),
      .f_req          (f_req),
      .f_addr         (f_addr),
      .f_gnt          (f_gnt),
      .f_rsp_valid    (f_rsp_valid),
      .f_rsp_err      (f_rsp_err),
      .f_rsp_data     (f_rsp_data),
      .d_req          (d_req),
      .d_we           (d_we),
      .d_unsigned     (d_unsigned),
      .d_size         (d_size),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_gnt          (d_gnt),
      .d_rsp_valid    (d_rsp_valid),
      .d_rsp_err      (d_rsp_err),
      .d_rsp_data     (d_rsp_data),
      .mem_address    (mem_address),
      .mem_data_in    (mem_data_in),
      .mem_read_write (mem_read_write),
      .mem_data_out   (mem_data_out)
   );

   function automatic int widx(input logic [31:0] a);
      return int'(((a - BASE) >> 2) % NWORDS);
   endfunction

   assign mem_data_out = phys[widx(mem_address)];

   always @(posedge clock) begin
      if (mem_read_write) phys[widx(mem_address)] <= mem_data_in;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit fault(input logic [31:0] a, input logic [1:0] sz);
      bit bad;
      bad = (a < BASE) || ((a - BASE) >= DEPTH) || (sz == 2'd3)
         || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
      return CHECK_EN && bad;
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input bit uns);
      int unsigned v, bits;
      if (sz == 2'd0) begin
         v = (w >> (8 * (a % 4))) & 32'hFF;
         bits = 8;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
         bits = 16;
      end else begin
         return w;
      end
      if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
      return v;
   endfunction

   function automatic logic [31:0] merge_val(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic [31:0] wd);
      int unsigned sh, mask;
      if (sz == 2'd0) begin
         sh   = 8 * (a % 4);
         mask = 32'hFF << sh;
      end else begin
         sh   = 16 * ((a % 4) / 2);
         mask = 32'hFFFF << sh;
      end
      return (w & ~mask) | ((wd << sh) & mask);
   endfunction

   // One clock: predict this cycle from current inputs, check port, then check responses after the edge.
   task automatic step();
      bit          e_fg = 0, e_dg = 0, e_we = 0, chk_addr = 1, in_rst;
      logic [31:0] e_addr = BASE, e_wd = '0;
      bit          ef_v = 0, ef_e = 0, ed_v = 0, ed_e = 0;
      logic [31:0] ef_d = '0, ed_d = '0;
      #1;
      in_rst = reset;
      if (reset) begin
         rmw_pend = 0;
         last_was_data = 0;
      end else if (rmw_pend) begin
         e_we = 1; e_addr = rmw_a; e_wd = rmw_w;
         ref_mem[widx(rmw_a)] = rmw_w;
         ed_v = 1;
         rmw_pend = 0;
      end else begin
         e_dg = d_req && (!f_req || !last_was_data);
         e_fg = f_req && !e_dg;
         if (e_fg) begin
            last_was_data = 0;
            ef_v = 1;
            if (fault(f_addr, 2'd2)) begin
               ef_e = 1; chk_addr = 0;
            end else begin
               e_addr = f_addr & ~32'd3;
               ef_d = ref_mem[widx(f_addr)];
            end
         end else if (e_dg) begin
            last_was_data = 1;
            if (fault(d_addr, d_size)) begin
               ed_v = 1; ed_e = 1; chk_addr = 0;
            end else begin
               e_addr = d_addr & ~32'd3;
               if (!d_we) begin
                  ed_v = 1;
                  ed_d = load_val(ref_mem[widx(d_addr)], d_addr, d_size, d_unsigned);
               end else if (d_size >= 2'd2) begin
                  ed_v = 1; e_we = 1; e_wd = d_wdata;
                  ref_mem[widx(d_addr)] = d_wdata;
               end else begin
                  rmw_pend = 1;
                  rmw_a = e_addr;
                  rmw_w = merge_val(ref_mem[widx(d_addr)], d_addr, d_size, d_wdata);
               end
            end
         end
      end
      obs_fg = f_gnt; obs_dg = d_gnt; obs_we = mem_read_write;
      check("f_gnt", 32'(f_gnt), 32'(e_fg));
      check("d_gnt", 32'(d_gnt), 32'(e_dg));
      check("mem_rw", 32'(mem_read_write), 32'(e_we));
      if (chk_addr) check("mem_addr", mem_address, e_addr);
      if (e_we || in_rst) check("mem_wdata", mem_data_in, e_wd);
      @(posedge clock);
      #1;
      check("f_rsp_valid", 32'(f_rsp_valid), 32'(ef_v));
      check("f_rsp_err", 32'(f_rsp_err), 32'(ef_e));
      if (ef_v || in_rst) check("f_rsp_data", f_rsp_data, ef_d);
      check("d_rsp_valid", 32'(d_rsp_valid), 32'(ed_v));
      check("d_rsp_err", 32'(d_rsp_err), 32'(ed_e));
      if (ed_v || in_rst) check("d_rsp_data", d_rsp_data, ed_d);
      @(negedge clock);
   endtask

   task automatic set_idle();
      f_req = 0; f_addr = BASE;
      d_req = 0; d_we = 0; d_unsigned = 0; d_size = 2'd2; d_addr = BASE; d_wdata = '0;
   endtask

   task automatic set_data(input bit we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input bit uns);
      d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_unsigned = uns;
   endtask

   initial begin
      for (int i = 0; i < int'(NWORDS); i++) begin
         phys[i] = $urandom;
         ref_mem[i] = phys[i];
      end
      phys[widx(32'h0100_0010)]    = 32'h8899_AABB;
      ref_mem[widx(32'h0100_0010)] = 32'h8899_AABB;
      last_was_data = 0;
      rmw_pend = 0;

      // Reset with both requesters asserting: nothing may be granted or written.
      @(negedge clock);
      reset = 1;
      set_idle();
      f_req = 1;
      set_data(1, 2'd2, BASE + 32'h40, 32'hDEAD_BEEF, 0);
      step();
      step();
      check("rst_mem_addr", mem_address, BASE);
      reset = 0;

      // Continuous contention: first goes to data, then strict alternation.
      f_addr = BASE + 32'h10;
      set_data(0, 2'd2, BASE + 32'h20, '0, 0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("alt_d_gnt", 32'(obs_dg), 32'((i % 2) == 0));
      end
      set_idle();

      // Fetch alone.
      f_req = 1; f_addr = 32'h0100_0010;
      step();
      check("fetch_word", f_rsp_data, 32'h8899_AABB);
      set_idle();

      // Byte load, signed and unsigned.
      set_data(0, 2'd0, 32'h0100_0013, '0, 0);
      step();
      check("lb_signed", d_rsp_data, 32'hFFFF_FF88);
      set_data(0, 2'd0, 32'h0100_0013, '0, 1);
      step();
      check("lb_unsigned", d_rsp_data, 32'h0000_0088);
      set_idle();

      // Half store via RMW; both requesters pushing in the write cycle.
      set_data(1, 2'd1, 32'h0100_0012, 32'hDEAD_1234, 0);
      step();
      check("rmw_wdata", mem_data_in, 32'h1234_AABB);
      f_req = 1; f_addr = BASE;
      set_data(0, 2'd2, BASE + 32'h8, '0, 0);
      step();
      check("rmw_no_gnt", 32'(obs_fg || obs_dg), 32'd0);
      check("rmw_ack", 32'(d_rsp_valid), 32'd1);
      set_idle();
      step();

      // Reset in the RMW write cycle aborts the write.
      set_data(1, 2'd1, 32'h0100_0010, 32'h0000_BEEF, 0);
      step();
      set_idle();
      reset = 1;
      step();
      check("rst_rmw_no_write", 32'(obs_we), 32'd0);
      reset = 0;
      set_data(0, 2'd2, 32'h0100_0010, '0, 0);
      step();
      check("rst_rmw_word", d_rsp_data, 32'h1234_AABB);
      set_idle();

`ifdef MEMARB_CHECK_EN
      // Misaligned word load and out-of-window fetch are rejected without memory access.
      set_data(0, 2'd2, 32'h0100_0002, '0, 0);
      step();
      check("err_ld_rw", 32'(obs_we), 32'd0);
      check("err_ld", 32'(d_rsp_err), 32'd1);
      set_idle();
      f_req = 1; f_addr = 32'h00FF_FFFC;
      step();
      check("err_fetch", 32'(f_rsp_err), 32'd1);
      set_idle();
`endif

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(0, 99) == 0);
         f_req  = ($urandom_range(0, 9) < 7);
         f_addr = ($urandom_range(0, 15) == 0) ? BASE - 32'd4 : BASE + 32'($urandom_range(0, 1023));
         d_req  = ($urandom_range(0, 9) < 7);
         d_we   = $urandom_range(0, 1) == 1;
         d_size = 2'($urandom_range(0, 3));
         d_unsigned = $urandom_range(0, 1) == 1;
         d_addr = ($urandom_range(0, 15) == 0) ? BASE + DEPTH : BASE + 32'($urandom_range(0, 1023));
         d_wdata = $urandom;
         step();
      end
      reset = 0;
      set_idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
